// File: rtl/gs_rawsignal_packer.sv
// Frames raw 16-bit sample bursts into header / packed-pair / trailer words for the FPGA-to-host FIFO.
// Define GS_PACK_CRC_EN to append a CRC-16-CCITT word after each trailer.
module gs_rawsignal_packer #(
    parameter logic [7:0] HEADER_TAG  = 8'hA5,
    parameter logic [7:0] TRAILER_TAG = 8'h5A
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iWriteRawSignal,
    input  logic [15:0] i16RawSignal,
    input  logic [7:0]  i8SignSelec,
    input  logic        iFifo_full,
    input  logic        iClrStatus,
    output logic        oFifo_wren,
    output logic [31:0] o32Fifo_data,
    output logic        oBusy,
    output logic        oOverflow,
    output logic [7:0]  o8DropCnt
);

`ifdef GS_PACK_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PACK_LO, S_PACK_HI, S_FLUSH, S_TRAILER, S_CRC
    } state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_q, crc_d;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PACK_LO, S_PACK_HI, S_FLUSH, S_TRAILER
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] seq_q, seq_d;
    logic        loss_q, loss_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_q, drop_d;
    logic        wren_q, wren_d;
    logic [31:0] data_q, data_d;

    logic        wr;
    logic        trl;
    logic        sample_drop;
    logic        word_lost;
    logic [31:0] word;
    logic [15:0] cnt_inc;
    logic [1:0]  events;
    logic [8:0]  drop_sum;

    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign word_lost = wr & iFifo_full;
    assign events    = {1'b0, sample_drop} + {1'b0, word_lost};

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        wr          = 1'b0;
        trl         = 1'b0;
        sample_drop = 1'b0;
        word        = 32'h0;
`ifdef GS_PACK_CRC_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iWriteRawSignal) begin
                    wr      = 1'b1;
                    word    = {HEADER_TAG, i8SignSelec, seq_q};
                    lo_d    = i16RawSignal;
                    cnt_d   = 16'd1;
                    state_d = S_PACK_HI;
`ifdef GS_PACK_CRC_EN
                    crc_d   = crc16_step(16'hFFFF, i16RawSignal);
`endif
                end
            end
            S_PACK_HI: begin
                wr = 1'b1;
                if (iWriteRawSignal) begin
                    word    = {i16RawSignal, lo_q};
                    cnt_d   = cnt_inc;
                    state_d = S_PACK_LO;
`ifdef GS_PACK_CRC_EN
                    crc_d   = crc16_step(crc_q, i16RawSignal);
`endif
                end else begin
                    word    = {16'h0000, lo_q};
                    state_d = S_FLUSH;
                end
            end
            S_PACK_LO: begin
                if (iWriteRawSignal) begin
                    lo_d    = i16RawSignal;
                    cnt_d   = cnt_inc;
                    state_d = S_PACK_HI;
`ifdef GS_PACK_CRC_EN
                    crc_d   = crc16_step(crc_q, i16RawSignal);
`endif
                end else begin
                    wr      = 1'b1;
                    trl     = 1'b1;
                    word    = {TRAILER_TAG, 6'b0, loss_q, 1'b0, cnt_q};
                    state_d = S_TRAILER;
                end
            end
            S_FLUSH: begin
                // A sample dropped here still belongs to the frame being closed.
                sample_drop = iWriteRawSignal;
                wr          = 1'b1;
                trl         = 1'b1;
                word        = {TRAILER_TAG, 6'b0, loss_q | sample_drop, 1'b1, cnt_q};
                state_d     = S_TRAILER;
            end
            S_TRAILER: begin
                sample_drop = iWriteRawSignal;
`ifdef GS_PACK_CRC_EN
                wr          = 1'b1;
                word        = {16'h0000, crc_q};
                state_d     = S_CRC;
`else
                state_d     = S_IDLE;
`endif
            end
`ifdef GS_PACK_CRC_EN
            S_CRC: begin
                sample_drop = iWriteRawSignal;
                state_d     = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (trl) seq_d = seq_q + 16'd1;
    end

    // Losses after a trailer has been registered are charged to the next frame.
    always_comb begin
        if (trl) loss_d = word_lost;
        else     loss_d = loss_q | sample_drop | word_lost;

        drop_sum = {1'b0, (iClrStatus ? 8'h00 : drop_q)} + {7'b0, events};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        ovf_d    = (events != 2'd0) ? 1'b1 : (iClrStatus ? 1'b0 : ovf_q);
        wren_d   = wr & ~iFifo_full;
        data_d   = wr ? word : data_q;
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            lo_q    <= 16'h0;
            cnt_q   <= 16'h0;
            seq_q   <= 16'h0;
            loss_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'h0;
            wren_q  <= 1'b0;
            data_q  <= 32'h0;
`ifdef GS_PACK_CRC_EN
            crc_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            loss_q  <= loss_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
`ifdef GS_PACK_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign oFifo_wren   = wren_q;
    assign o32Fifo_data = data_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oOverflow    = ovf_q;
    assign o8DropCnt    = drop_q;

endmodule
